pipeline_seq_ctrl: RTL and testbench
====================================

# pipeline_seq_ctrl

Parametrised frame-pipeline sequencer. Walks a frame through NUM_STAGES processing stages (stage 0 = camera capture into buffer RAM, later stages = grayscale and downstream filters) using a one-hot enable / done handshake per stage. Runs either a single frame per start or continuous multi-frame capture with a frame counter. Sits between the user start/abort controls and the buffer-RAM, camera and processing modules.

## Interface
Parameters:
- NUM_STAGES, 3, number of sequenced stages (2..8)
- FRAMES_W, 8, width of frame_count and frames_completed
- TIMEOUT_CYCLES, 65535, watchdog limit per stage (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sequencing (level, sampled in IDLE)
- abort  in  1  synchronous abort, highest priority
- continuous  in  1  1 = loop frames, 0 = single frame
- frame_count  in  FRAMES_W  frames to run in continuous mode; 0 = unlimited
- stage_done  in  NUM_STAGES  per-stage completion pulse/level
- stage_enable  out  NUM_STAGES  one-hot enable of the active stage
- rwm_enable  out  1  buffer RAM enable, 1 whenever any stage is active
- rw  out  1  buffer RAM direction: 1 = write (stage 0), 0 = read
- busy  out  1  1 in any state other than IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- frames_completed  out  FRAMES_W  frames completed since last start
- error  out  1  watchdog fault flag (constant 0 without SEQ_TIMEOUT_EN)

## Operation
- States: IDLE, RUN (with stage index stg, width $clog2(NUM_STAGES)), FRAME_END, ERROR.
- IDLE: all enables 0, rw 0. start=1 → RUN with stg=0; frames_completed cleared to 0 on that same edge.
- RUN: stage_enable = one-hot(stg); only stage_done[stg] is observed, done bits of other stages are ignored. stage_done[stg]=1 with stg<NUM_STAGES-1 → stg+1. With stg=NUM_STAGES-1 → FRAME_END.
- FRAME_END (one cycle): frame_done=1, frames_completed increments (saturating at all-ones). Next state: RUN stg=0 if continuous=1 and (frame_count==0 or frames_completed+1 < frame_count); otherwise IDLE.
- abort=1 in any state → IDLE next edge, overrides start, done and timeout; frames_completed retained.
- ERROR: all enables 0, error=1, busy=1; exits only on abort → IDLE (error cleared); start ignored.
- continuous is sampled only in FRAME_END; changing it mid-frame has no effect on the current frame.

## Timing
- All outputs registered; reset values: stage_enable 0, rwm_enable 0, rw 0, busy 0, frame_done 0, frames_completed 0, error 0, state IDLE, stg 0.
- start high at edge N → stage_enable[0], rwm_enable, rw, busy high from edge N+1.
- stage_done[k] high at edge M → stage_enable moves to k+1 at edge M+1 (one-cycle handoff, no idle gap).
- Last-stage done at edge M → frame_done high during cycle M+1..M+2; next frame's stage 0 enabled at edge M+2.
- Single-stage-done latency: min 1 cycle per stage; frame minimum NUM_STAGES+1 cycles.
- rst_n deassertion mid-frame is not required to resume; reset always returns to IDLE.

## Configuration
- SEQ_TIMEOUT_EN defined: per-stage cycle counter cleared on every stage entry; reaching TIMEOUT_CYCLES while in RUN without stage_done[stg] → ERROR next edge. Done on the same edge as the limit wins (advance, no error).
- Undefined: no counter logic, ERROR unreachable, error tied 0.

## Structure
- Shared package pipeline_seq_pkg: state enum (IDLE, RUN, FRAME_END, ERROR), stage-index width function, rw encodings RW_WRITE=1 / RW_READ=0.
- One sub-module seq_watchdog (counter + limit compare), instantiated only under SEQ_TIMEOUT_EN.

## Test plan
- Reset, then start pulse with NUM_STAGES=3, continuous=0, done each stage after 5 cycles → enables 001,010,100 in order, rw=1 only during stage 0, one frame_done, frames_completed=1, back to IDLE.
- continuous=1, frame_count=4 → exactly 4 frame_done pulses, frames_completed=4, busy drops after 4th FRAME_END.
- stage_done[2] asserted while stage 0 active → ignored, stage_enable stays 001.
- abort asserted in stage 1 simultaneously with stage_done[1] → IDLE next edge, all enables 0, frames_completed unchanged.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=20, stage 1 never done → error=1 after 20 cycles in stage 1; start ignored; abort clears to IDLE.
- continuous=1, frame_count=0, FRAMES_W=2 → runs past 3 frames, frames_completed saturates at 3, sequencing continues until abort.

Source files
------------

// File: rtl/pipeline_seq_ctrl_pkg.sv
// rtl/pipeline_seq_ctrl_pkg.sv - shared types and helpers for the frame-pipeline sequencer
package pipeline_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        FRAME_END = 2'd2,
        ERROR     = 2'd3
    } seq_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Stage index width; a single-bit index is kept even for degenerate counts.
    function automatic int stg_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipeline_seq_ctrl_watchdog.sv
// rtl/pipeline_seq_ctrl_watchdog.sv - per-stage cycle counter with limit compare
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of completed cycles in the current stage; the
    // cycle in which it equals LIMIT is the last one allowed.
    assign expired = (cnt >= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_seq_ctrl.sv
// rtl/pipeline_seq_ctrl.sv - frame-pipeline stage sequencer with single/continuous modes
// Optional stage watchdog enabled by defining SEQ_TIMEOUT_EN.
module pipeline_seq_ctrl
    import pipeline_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int FRAMES_W       = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  continuous,
    input  logic [FRAMES_W-1:0]   frame_count,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_enable,
    output logic                  rwm_enable,
    output logic                  rw,
    output logic                  busy,
    output logic                  frame_done,
    output logic [FRAMES_W-1:0]   frames_completed,
    output logic                  error
);

    localparam int STG_W = stg_width(NUM_STAGES);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);

    seq_state_t       state;
    logic [STG_W-1:0] stg;
    logic             cur_done;
    logic             more_frames;
    logic             timeout_hit;
    logic [FRAMES_W:0] fc_next;

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [STG_W-1:0] idx);
        return NUM_STAGES'(1) << idx;
    endfunction

    assign cur_done = stage_done[stg];

    // Extra bit keeps the "this frame plus the ones already done" compare exact at all-ones.
    assign fc_next     = {1'b0, frames_completed} + (FRAMES_W + 1)'(1);
    assign more_frames = continuous &&
                         ((frame_count == '0) || (fc_next < {1'b0, frame_count}));

`ifdef SEQ_TIMEOUT_EN
    logic wd_expired;

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state != RUN) || cur_done),
        .expired(wd_expired)
    );

    assign timeout_hit = wd_expired;
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            stg              <= '0;
            stage_enable     <= '0;
            rwm_enable       <= 1'b0;
            rw               <= RW_READ;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            frames_completed <= '0;
            error            <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            stg          <= '0;
            stage_enable <= '0;
            rwm_enable   <= 1'b0;
            rw           <= RW_READ;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        state            <= RUN;
                        stg              <= '0;
                        stage_enable     <= onehot('0);
                        rwm_enable       <= 1'b1;
                        rw               <= RW_WRITE;
                        busy             <= 1'b1;
                        frames_completed <= '0;
                    end
                end
                RUN: begin
                    // Done takes precedence over a watchdog expiry on the same edge.
                    if (cur_done) begin
                        if (stg == LAST_STG) begin
                            state        <= FRAME_END;
                            stg          <= '0;
                            stage_enable <= '0;
                            rwm_enable   <= 1'b0;
                            rw           <= RW_READ;
                            frame_done   <= 1'b1;
                        end else begin
                            stg          <= stg + 1'b1;
                            stage_enable <= onehot(stg + 1'b1);
                            rw           <= RW_READ;
                        end
                    end else if (timeout_hit) begin
                        state        <= ERROR;
                        stage_enable <= '0;
                        rwm_enable   <= 1'b0;
                        rw           <= RW_READ;
                        error        <= 1'b1;
                    end
                end
                FRAME_END: begin
                    frame_done <= 1'b0;
                    if (!(&frames_completed)) begin
                        frames_completed <= frames_completed + FRAMES_W'(1);
                    end
                    if (more_frames) begin
                        state        <= RUN;
                        stg          <= '0;
                        stage_enable <= onehot('0);
                        rwm_enable   <= 1'b1;
                        rw           <= RW_WRITE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ERROR: begin
                    error <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// tb/tb_pipeline_seq_ctrl.sv - directed self-checking bench for pipeline_seq_ctrl
module tb_pipeline_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, continuous;
    logic [7:0] frame_count;
    logic [2:0] stage_done;
    logic [2:0] stage_enable;
    logic       rwm_enable, rw, busy, frame_done, error;
    logic [7:0] frames_completed;

    logic       start2, abort2, continuous2;
    logic [1:0] frame_count2;
    logic [2:0] stage_done2;
    logic [2:0] stage_enable2;
    logic       rwm_enable2, rw2, busy2, frame_done2, error2;
    logic [1:0] frames_completed2;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    pipeline_seq_ctrl #(
        .NUM_STAGES(3), .FRAMES_W(8), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .continuous(continuous), .frame_count(frame_count), .stage_done(stage_done),
        .stage_enable(stage_enable), .rwm_enable(rwm_enable), .rw(rw), .busy(busy),
        .frame_done(frame_done), .frames_completed(frames_completed), .error(error)
    );

    pipeline_seq_ctrl #(
        .NUM_STAGES(3), .FRAMES_W(2), .TIMEOUT_CYCLES(20)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .continuous(continuous2), .frame_count(frame_count2), .stage_done(stage_done2),
        .stage_enable(stage_enable2), .rwm_enable(rwm_enable2), .rw(rw2), .busy(busy2),
        .frame_done(frame_done2), .frames_completed(frames_completed2), .error(error2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs stages 0..2 with `gap` idle cycles before each done; ends in FRAME_END.
    task automatic do_frame(input int gap);
        for (int k = 0; k < 3; k++) begin
            repeat (gap) tick();
            check("stage_en", stage_enable, 32'(1 << k));
            check("rw_dir", rw, (k == 0) ? 1 : 0);
            check("rwm_en", rwm_enable, 1);
            stage_done = 3'(1 << k);
            tick();
            stage_done = '0;
        end
        check("frame_done_pulse", frame_done, 1);
        check("fe_enables_off", stage_enable, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; continuous = 0; frame_count = 0; stage_done = 0;
        start2 = 0; abort2 = 0; continuous2 = 0; frame_count2 = 0; stage_done2 = 0;
        repeat (3) tick();
        check("rst_stage_en", stage_enable, 0);
        check("rst_rwm", rwm_enable, 0);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frames", frames_completed, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        tick();

        // Single frame, done on the fifth cycle of every stage.
        start = 1; tick(); start = 0;
        check("s1_busy", busy, 1);
        do_frame(4);
        tick();
        check("s1_frame_done_low", frame_done, 0);
        check("s1_busy_low", busy, 0);
        check("s1_frames", frames_completed, 1);
        check("s1_idle_en", stage_enable, 0);

        // Continuous, four frames, then stop.
        continuous = 1; frame_count = 8'd4;
        start = 1; tick(); start = 0;
        check("c4_cleared", frames_completed, 0);
        for (int f = 0; f < 4; f++) begin
            do_frame(1);
            tick();
            if (f < 3) begin
                check("c4_next_stage0", stage_enable, 3'b001);
                check("c4_frames", frames_completed, f + 1);
            end
        end
        check("c4_busy_low", busy, 0);
        check("c4_frames_final", frames_completed, 4);
        check("c4_en_off", stage_enable, 0);

        // Unlimited run: foreign done ignored, then abort mid-frame with done.
        frame_count = 8'd0;
        start = 1; tick(); start = 0;
        stage_done = 3'b100;
        repeat (3) tick();
        check("ignore_other_done", stage_enable, 3'b001);
        stage_done = '0;
        do_frame(1); tick();
        do_frame(1); tick();
        check("ab_frames_before", frames_completed, 2);
        stage_done = 3'b001; tick(); stage_done = '0;
        check("ab_stage1", stage_enable, 3'b010);
        abort = 1; stage_done = 3'b010; tick(); abort = 0; stage_done = '0;
        check("ab_en_off", stage_enable, 0);
        check("ab_busy", busy, 0);
        check("ab_rwm", rwm_enable, 0);
        check("ab_frames_kept", frames_completed, 2);
        tick();
        check("ab_stays_idle", busy, 0);
        continuous = 0;

`ifdef SEQ_TIMEOUT_EN
        // Stage 1 never completes: error after 20 cycles in it.
        start = 1; tick(); start = 0;
        stage_done = 3'b001; tick(); stage_done = '0;
        repeat (19) tick();
        check("to_no_err_yet", error, 0);
        check("to_still_stage1", stage_enable, 3'b010);
        tick();
        check("to_error", error, 1);
        check("to_en_off", stage_enable, 0);
        check("to_busy", busy, 1);
        start = 1; tick(); start = 0;
        check("to_start_ignored", error, 1);
        check("to_start_ignored_en", stage_enable, 0);
        abort = 1; tick(); abort = 0;
        check("to_abort_clear", error, 0);
        check("to_abort_idle", busy, 0);
`else
        check("no_to_error", error, 0);
`endif

        // Two-bit counter, unlimited frames, every stage done immediately.
        continuous2 = 1; frame_count2 = 2'd0; stage_done2 = 3'b111;
        start2 = 1; tick(); start2 = 0;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (frame_done2) pulses++;
        end
        check("sat_pulses", pulses, 6);
        check("sat_frames", frames_completed2, 3);
        check("sat_busy", busy2, 1);
        abort2 = 1; tick(); abort2 = 0;
        check("sat_abort_idle", busy2, 0);
        check("sat_abort_kept", frames_completed2, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
